// File: rtl/rgb_pkg.sv
// Shared state encoding, default colour table and clamped channel step helper
// used by rgb_fader and its channel ramps.
package rgb_pkg;

  // Widest channel the step helper supports; narrower channels are zero-extended.
  localparam int MAX_CH_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FADE  = 2'd1,
    ST_BLINK = 2'd2
  } state_e;

  // 8 bits per channel, R,G,B from MSB; element 0 is the rightmost entry.
  localparam logic [7:0][23:0] DEFAULT_LUT = {
    24'h000000, 24'h000000, 24'h000000, 24'h000000,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  // One extra bit keeps cur+step and cur-step from wrapping at either rail.
  function automatic logic [MAX_CH_W-1:0] step_toward(
    input logic [MAX_CH_W-1:0] cur,
    input logic [MAX_CH_W-1:0] tgt,
    input logic [MAX_CH_W-1:0] step
  );
    logic [MAX_CH_W:0] cur_x;
    logic [MAX_CH_W:0] tgt_x;
    logic [MAX_CH_W:0] step_x;
    logic [MAX_CH_W:0] res_x;
    cur_x  = {1'b0, cur};
    tgt_x  = {1'b0, tgt};
    step_x = {1'b0, step};
    if (tgt_x > cur_x) begin
      if ((tgt_x - cur_x) > step_x) res_x = cur_x + step_x;
      else                          res_x = tgt_x;
    end else if (cur_x > tgt_x) begin
      if ((cur_x - tgt_x) > step_x) res_x = cur_x - step_x;
      else                          res_x = tgt_x;
    end else begin
      res_x = cur_x;
    end
    return res_x[MAX_CH_W-1:0];
  endfunction

endpackage

// File: rtl/rgb_fader_if.sv
// Selector, colour-table write port and colour outputs of rgb_fader.
interface rgb_fader_if #(
  parameter int CH_W  = 8,
  parameter int SEL_W = 3
);
  logic [SEL_W-1:0]  sel;
  logic              lut_we;
  logic [SEL_W-1:0]  lut_addr;
  logic [3*CH_W-1:0] lut_wdata;
  logic [3*CH_W-1:0] rgb;
  logic [3*CH_W-1:0] target;
  logic              settled;

  modport master (
    output sel, lut_we, lut_addr, lut_wdata,
    input  rgb, target, settled
  );

  modport slave (
    input  sel, lut_we, lut_addr, lut_wdata,
    output rgb, target, settled
  );
endinterface

// File: rtl/rgb_channel_ramp.sv
// One colour channel register that either steps toward its target, loads a
// value directly, or holds; flags when it already equals the target.
module rgb_channel_ramp
  import rgb_pkg::*;
#(
  parameter int CH_W = 8,
  parameter int STEP = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            step_en,
  input  logic            load_en,
  input  logic [CH_W-1:0] load_val,
  input  logic [CH_W-1:0] tgt,
  output logic [CH_W-1:0] val,
  output logic [CH_W-1:0] val_nxt,
  output logic            eq
);

  localparam logic [MAX_CH_W-1:0] STEP_X = MAX_CH_W'(STEP);

  logic [CH_W-1:0]     val_q;
  logic [CH_W-1:0]     val_d;
  logic [MAX_CH_W-1:0] stepped_s;

  // Next channel value: direct load wins over a fade step.
  always_comb begin
    stepped_s = step_toward(MAX_CH_W'(val_q), MAX_CH_W'(tgt), STEP_X);
    if (load_en)      val_d = load_val;
    else if (step_en) val_d = stepped_s[CH_W-1:0];
    else              val_d = val_q;
  end

  // Channel register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) val_q <= '0;
    else        val_q <= val_d;
  end

  assign val     = val_q;
  assign val_nxt = val_d;
  assign eq      = (val_q == tgt);

endmodule

// File: rtl/rgb_fader.sv
// Colour table lookup with stepped fade toward the selected colour.
// Optional fault blink on selector 3 is built when RGB_BLINK_EN is defined.
module rgb_fader
  import rgb_pkg::*;
#(
  parameter int CH_W        = 8,
  parameter int SEL_W       = 3,
  parameter int TICK_DIV    = 1000,
  parameter int STEP        = 4,
  parameter int BLINK_TICKS = 64
) (
  input logic        clk,
  input logic        rst_n,
  rgb_fader_if.slave bus
);

  localparam int DEPTH = 2 ** SEL_W;
  localparam int RGB_W = 3 * CH_W;
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] FADE = ST_FADE;

  // Left-align an 8-bit default channel into CH_W bits (MSBs kept).
  function automatic logic [CH_W-1:0] scale_ch(input logic [7:0] v);
    logic [MAX_CH_W+7:0] wide;
    wide = {v, {MAX_CH_W{1'b0}}};
    return wide[MAX_CH_W+7 -: CH_W];
  endfunction

  function automatic logic [RGB_W-1:0] default_entry(input int idx);
    logic [23:0] src;
    if (idx < 8) src = DEFAULT_LUT[idx[2:0]];
    else         src = 24'h000000;
    return {scale_ch(src[23:16]), scale_ch(src[15:8]), scale_ch(src[7:0])};
  endfunction

  logic [RGB_W-1:0] lut_q [DEPTH];
  logic [RGB_W-1:0] lut_d [DEPTH];
  logic [SEL_W-1:0] sel_q;
  logic [RGB_W-1:0] target_q;
  logic [RGB_W-1:0] target_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic             settled_q;
  logic             settled_d;

  logic             tick_s;
  logic             step_en_s;
  logic             load_en_s;
  logic [RGB_W-1:0] load_val_s;
  logic [RGB_W-1:0] rgb_s;
  logic [RGB_W-1:0] rgb_nxt_s;
  logic [2:0]       ch_eq_s;
  logic             all_eq_s;
  logic             blink_req_s;

  assign tick_s    = (cnt_q == CNT_MAX);
  assign all_eq_s  = &ch_eq_s;
  assign step_en_s = (state_q == FADE) && tick_s;
  assign target_d  = lut_q[sel_q];

  // A table write lands at the edge where lut_we is high.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.lut_we && (bus.lut_addr == SEL_W'(i))) lut_d[i] = bus.lut_wdata;
      else                                           lut_d[i] = lut_q[i];
    end
  end

  always_comb begin
    if (tick_s) cnt_d = '0;
    else        cnt_d = cnt_q + CNT_W'(1);
  end

`ifdef RGB_BLINK_EN
  localparam logic [1:0]       BLINK     = ST_BLINK;
  localparam logic [SEL_W-1:0] FAULT_SEL = SEL_W'(3);
  localparam int               BLK_W     = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BLK_W-1:0] BLK_MAX   = BLK_W'(BLINK_TICKS - 1);

  logic [BLK_W-1:0] blk_cnt_q;
  logic [BLK_W-1:0] blk_cnt_d;
  logic             blk_on_q;
  logic             blk_on_d;

  assign blink_req_s = (sel_q == FAULT_SEL);
  assign load_en_s   = (state_q == BLINK);
  assign load_val_s  = blk_on_q ? target_q : '0;

  // Blink phase restarts in the "on" half each time BLINK is entered.
  always_comb begin
    if (state_q != BLINK) begin
      blk_cnt_d = '0;
      blk_on_d  = 1'b1;
    end else if (tick_s && (blk_cnt_q == BLK_MAX)) begin
      blk_cnt_d = '0;
      blk_on_d  = ~blk_on_q;
    end else if (tick_s) begin
      blk_cnt_d = blk_cnt_q + BLK_W'(1);
      blk_on_d  = blk_on_q;
    end else begin
      blk_cnt_d = blk_cnt_q;
      blk_on_d  = blk_on_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt_q <= '0;
      blk_on_q  <= 1'b1;
    end else begin
      blk_cnt_q <= blk_cnt_d;
      blk_on_q  <= blk_on_d;
    end
  end
`else
  assign blink_req_s = 1'b0;
  assign load_en_s   = 1'b0;
  assign load_val_s  = '0;
`endif

  // FADE ends either when a tick lands on the target or the target comes back to rgb.
  always_comb begin
    state_d = state_q;
    if (blink_req_s) begin
`ifdef RGB_BLINK_EN
      state_d = BLINK;
`else
      state_d = state_q;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (all_eq_s) state_d = IDLE;
          else          state_d = FADE;
        end
        FADE: begin
          if (all_eq_s || (tick_s && (rgb_nxt_s == target_q))) state_d = IDLE;
          else                                                 state_d = FADE;
        end
`ifdef RGB_BLINK_EN
        BLINK:   state_d = FADE;
`endif
        default: state_d = IDLE;
      endcase
    end
    settled_d = (state_d == IDLE) && (target_d == rgb_nxt_s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) lut_q[i] <= default_entry(i);
      sel_q     <= '0;
      target_q  <= '0;
      cnt_q     <= '0;
      state_q   <= IDLE;
      settled_q <= 1'b1;
    end else begin
      for (int i = 0; i < DEPTH; i++) lut_q[i] <= lut_d[i];
      sel_q     <= bus.sel;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      settled_q <= settled_d;
    end
  end

  for (genvar c = 0; c < 3; c++) begin : g_ch
    rgb_channel_ramp #(
      .CH_W (CH_W),
      .STEP (STEP)
    ) u_ramp (
      .clk      (clk),
      .rst_n    (rst_n),
      .step_en  (step_en_s),
      .load_en  (load_en_s),
      .load_val (load_val_s[c*CH_W +: CH_W]),
      .tgt      (target_q[c*CH_W +: CH_W]),
      .val      (rgb_s[c*CH_W +: CH_W]),
      .val_nxt  (rgb_nxt_s[c*CH_W +: CH_W]),
      .eq       (ch_eq_s[c])
    );
  end

  assign bus.rgb     = rgb_s;
  assign bus.target  = target_q;
  assign bus.settled = settled_q;

endmodule

// File: tb/tb_rgb_fader.sv
// Bench for rgb_fader: directed fade sequences, a vector table and a randomized
// run checked each cycle against a behavioural colour-fade model.
module tb_rgb_fader;

  localparam int CH_W        = 8;
  localparam int SEL_W       = 3;
  localparam int TICK_DIV    = 4;
  localparam int STEP        = 64;
  localparam int BLINK_TICKS = 2;

  logic clk;
  logic rst_n;

  rgb_fader_if #(.CH_W(CH_W), .SEL_W(SEL_W)) bus ();

  rgb_fader #(
    .CH_W        (CH_W),
    .SEL_W       (SEL_W),
    .TICK_DIV    (TICK_DIV),
    .STEP        (STEP),
    .BLINK_TICKS (BLINK_TICKS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic        we;
    logic [2:0]  addr;
    logic [23:0] wdata;
    int          hold;
    logic [23:0] exp_rgb;
    logic [23:0] exp_tgt;
    logic        exp_settled;
  } vec_t;

  vec_t        vecs [8];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [23:0] seq_q [$];

  // Behavioural model: colours, table, selector latch, fade flag, tick phase.
  logic [23:0] m_table [8];
  logic [23:0] m_rgb;
  logic [23:0] m_tgt;
  int          m_sel_q;
  bit          m_fading;
  int          m_cnt;
  bit          m_settled;
  bit          model_on;

  function automatic int chan(input logic [23:0] v, input int c);
    logic [23:0] s;
    s = v >> (8 * (2 - c));
    return int'(s[7:0]);
  endfunction

  task automatic model_reset();
    m_table   = '{24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
                  24'h000000, 24'h000000, 24'h000000, 24'h000000};
    m_rgb     = 24'h000000;
    m_tgt     = 24'h000000;
    m_sel_q   = 0;
    m_fading  = 1'b0;
    m_cnt     = 0;
    m_settled = 1'b1;
  endtask

  task automatic model_update();
    bit          tick;
    logic [23:0] nrgb;
    logic [23:0] ntgt;
    int          cv;
    int          tv;
    int          d;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tick = (m_cnt == TICK_DIV - 1);
    nrgb = m_rgb;
    if (m_fading && tick) begin
      for (int c = 0; c < 3; c++) begin
        cv = chan(m_rgb, c);
        tv = chan(m_tgt, c);
        d  = tv - cv;
        if (d > STEP)       cv = cv + STEP;
        else if (d < -STEP) cv = cv - STEP;
        else                cv = tv;
        nrgb[8*(2-c) +: 8] = 8'(cv);
      end
    end
    if (!m_fading) m_fading = (m_rgb != m_tgt);
    else           m_fading = (nrgb != m_tgt);
    ntgt = m_table[m_sel_q];
    if (bus.lut_we) m_table[bus.lut_addr] = bus.lut_wdata;
    m_sel_q   = int'(bus.sel);
    m_cnt     = tick ? 0 : m_cnt + 1;
    m_rgb     = nrgb;
    m_tgt     = ntgt;
    m_settled = !m_fading && (ntgt == nrgb);
  endtask

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step_clk();
    @(posedge clk);
    model_update();
    #1;
    if (model_on) begin
      check("model_rgb", bus.rgb, m_rgb);
      check("model_target", bus.target, m_tgt);
      check("model_settled", {23'd0, bus.settled}, {23'd0, m_settled});
    end
  endtask

  // Collect every distinct rgb value until settled, bounded by max cycles.
  task automatic record_until_settled(input int max, output bit ok);
    logic [23:0] prev;
    prev = bus.rgb;
    ok   = 1'b0;
    seq_q.delete();
    for (int i = 0; i < max; i++) begin
      step_clk();
      if (bus.rgb !== prev) begin
        seq_q.push_back(bus.rgb);
        prev = bus.rgb;
      end
      if (bus.settled === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_seq(input string name, input logic [23:0] e0, input logic [23:0] e1,
                           input logic [23:0] e2, input logic [23:0] e3);
    logic [23:0] exp [4];
    exp = '{e0, e1, e2, e3};
    check({name, "_len"}, 24'(seq_q.size()), 24'd4);
    for (int i = 0; i < 4; i++)
      check({name, "_step"}, (i < seq_q.size()) ? seq_q[i] : 24'hBAD0BA, exp[i]);
  endtask

  task automatic go_sel(input logic [2:0] s, input int max, output bit ok);
    bus.sel = s;
    step_clk();
    step_clk();
    record_until_settled(max, ok);
  endtask

  task automatic wait_rgb(input logic [23:0] v, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (bus.rgb === v) begin
        ok = 1'b1;
        break;
      end
      step_clk();
    end
  endtask

  initial begin
    bit ok;
    int toggles;
    int bad;
    logic [23:0] prev;
    logic [2:0] rs;

    model_on      = 1'b1;
    rst_n         = 1'b0;
    bus.sel       = 3'd0;
    bus.lut_we    = 1'b0;
    bus.lut_addr  = 3'd0;
    bus.lut_wdata = 24'h000000;
    model_reset();

    // Reset values, held and after release.
    repeat (3) step_clk();
    check("reset_rgb", bus.rgb, 24'h000000);
    check("reset_target", bus.target, 24'h000000);
    check("reset_settled", {23'd0, bus.settled}, 24'd1);
    #3 rst_n = 1'b1;
    step_clk();
    check("post_reset_rgb", bus.rgb, 24'h000000);
    check("post_reset_settled", {23'd0, bus.settled}, 24'd1);

    // Fade 0 -> FF0000 with two-cycle target latency and clamped last step.
    bus.sel = 3'd2;
    step_clk();
    check("t2_target_lag", bus.target, 24'h000000);
    check("t2_settled_lag", {23'd0, bus.settled}, 24'd1);
    step_clk();
    check("t2_target", bus.target, 24'hFF0000);
    check("t2_settled_drop", {23'd0, bus.settled}, 24'd0);
    record_until_settled(60, ok);
    check("t2_settle_timeout", {23'd0, ok}, 24'd1);
    check_seq("t2_seq", 24'h400000, 24'h800000, 24'hC00000, 24'hFF0000);

    // Retarget mid-fade at R=80: R falls while B rises on the same ticks.
    go_sel(3'd0, 60, ok);
    check("t3_back_to_zero", bus.rgb, 24'h000000);
    bus.sel = 3'd2;
    wait_rgb(24'h800000, 40, ok);
    check("t3_reach_80", {23'd0, ok}, 24'd1);
    go_sel(3'd1, 60, ok);
    check("t3_settle_timeout", {23'd0, ok}, 24'd1);
    check_seq("t3_seq", 24'h400040, 24'h000080, 24'h0000C0, 24'h0000FF);

    // Write to the selected entry reaches target one cycle after the write edge.
    bus.lut_we    = 1'b1;
    bus.lut_addr  = 3'd1;
    bus.lut_wdata = 24'h00FF00;
    step_clk();
    bus.lut_we = 1'b0;
    check("t4_target_write_edge", bus.target, 24'h0000FF);
    step_clk();
    check("t4_target_new", bus.target, 24'h00FF00);
    check("t4_settled_drop", {23'd0, bus.settled}, 24'd0);
    record_until_settled(60, ok);
    check("t4_settle_timeout", {23'd0, ok}, 24'd1);
    check("t4_rgb", bus.rgb, 24'h00FF00);

    // Asynchronous reset mid-fade restores outputs and the default table.
    go_sel(3'd0, 60, ok);
    bus.sel = 3'd2;
    wait_rgb(24'h400000, 40, ok);
    check("t5_reach_40", {23'd0, ok}, 24'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_rgb", bus.rgb, 24'h000000);
    check("t5_async_target", bus.target, 24'h000000);
    check("t5_async_settled", {23'd0, bus.settled}, 24'd1);
    model_reset();
    bus.sel = 3'd1;
    step_clk();
    step_clk();
    #2 rst_n = 1'b1;
    step_clk();
    step_clk();
    check("t5_table_restored", bus.target, 24'h0000FF);
    record_until_settled(60, ok);
    check("t5_rgb", bus.rgb, 24'h0000FF);

    // Vector table.
    vecs[0] = '{3'd0, 1'b0, 3'd0, 24'h000000, 30, 24'h000000, 24'h000000, 1'b1};
    vecs[1] = '{3'd2, 1'b0, 3'd0, 24'h000000, 30, 24'hFF0000, 24'hFF0000, 1'b1};
`ifdef RGB_BLINK_EN
    vecs[2] = '{3'd6, 1'b0, 3'd0, 24'h000000, 30, 24'h000000, 24'h000000, 1'b1};
`else
    vecs[2] = '{3'd3, 1'b0, 3'd0, 24'h000000, 30, 24'hFF00FF, 24'hFF00FF, 1'b1};
`endif
    vecs[3] = '{3'd1, 1'b0, 3'd0, 24'h000000, 30, 24'h0000FF, 24'h0000FF, 1'b1};
    vecs[4] = '{3'd4, 1'b0, 3'd0, 24'h000000, 30, 24'h000000, 24'h000000, 1'b1};
    vecs[5] = '{3'd5, 1'b1, 3'd5, 24'h123456, 30, 24'h123456, 24'h123456, 1'b1};
    vecs[6] = '{3'd7, 1'b1, 3'd7, 24'hFFFFFF, 30, 24'hFFFFFF, 24'hFFFFFF, 1'b1};
    vecs[7] = '{3'd7, 1'b1, 3'd7, 24'h000000, 30, 24'h000000, 24'h000000, 1'b1};
    for (int v = 0; v < 8; v++) begin
      bus.sel       = vecs[v].sel;
      bus.lut_we    = vecs[v].we;
      bus.lut_addr  = vecs[v].addr;
      bus.lut_wdata = vecs[v].wdata;
      step_clk();
      bus.lut_we = 1'b0;
      repeat (vecs[v].hold - 1) step_clk();
      check("vec_rgb", bus.rgb, vecs[v].exp_rgb);
      check("vec_target", bus.target, vecs[v].exp_tgt);
      check("vec_settled", {23'd0, bus.settled}, {23'd0, vecs[v].exp_settled});
    end

    // Randomized selector changes and table writes, model-checked every cycle.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        rs = 3'($urandom_range(0, 7));
`ifdef RGB_BLINK_EN
        if (rs == 3'd3) rs = 3'd2;
`endif
        bus.sel = rs;
      end
      if ($urandom_range(0, 7) == 0) begin
        bus.lut_we    = 1'b1;
        bus.lut_addr  = 3'($urandom_range(4, 7));
        bus.lut_wdata = 24'($urandom);
      end else begin
        bus.lut_we = 1'b0;
      end
      step_clk();
    end
    bus.lut_we = 1'b0;

    // Selector 3: fault blink when built in, otherwise an ordinary fade.
`ifdef RGB_BLINK_EN
    model_on = 1'b0;
    bus.sel  = 3'd3;
    repeat (4) step_clk();
    toggles = 0;
    bad     = 0;
    prev    = bus.rgb;
    for (int i = 0; i < 48; i++) begin
      step_clk();
      if (bus.settled !== 1'b0) bad++;
      if ((bus.rgb !== 24'hFF00FF) && (bus.rgb !== 24'h000000)) bad++;
      if (bus.rgb !== prev) toggles++;
      prev = bus.rgb;
    end
    check("t6_blink_bad_cycles", 24'(bad), 24'd0);
    check("t6_blink_toggles", 24'(toggles >= 5), 24'd1);
`else
    toggles = 0;
    bad     = 0;
    prev    = 24'h000000;
    go_sel(3'd3, 60, ok);
    check("t6_settle_timeout", {23'd0, ok}, 24'd1);
    check("t6_rgb", bus.rgb, 24'hFF00FF);
    check("t6_target", bus.target, 24'hFF00FF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rgb_fader.md
Name: rgb_fader

Overview:
Parametrised successor to the heating/cooling colour lookup. A writable colour table, indexed by a selector, drives a 3-channel RGB output. The output fades toward each new target colour in fixed steps instead of jumping to it. It sits between the thermostat control logic and the LED driver; `sel` is normally {heating,cooling}, zero-extended.

Parameters:
- CH_W, 8, bits per colour channel; rgb width is 3*CH_W, ordered R,G,B from MSB.
- SEL_W, 3, selector/address width; table depth is 2**SEL_W.
- TICK_DIV, 1000, clk cycles per fade step; minimum 1.
- STEP, 4, maximum per-channel change per fade step; 1 to 2**CH_W-1.
- BLINK_TICKS, 64, fade ticks per blink half-period; used only with RGB_BLINK_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sel  in  SEL_W  colour selector.
- lut_we  in  1  table write enable.
- lut_addr  in  SEL_W  table write address.
- lut_wdata  in  3*CH_W  table write data.
- rgb  out  3*CH_W  current displayed colour, registered.
- target  out  3*CH_W  colour currently being approached, registered.
- settled  out  1  high when rgb == target and no fade is pending.

Behaviour:
Reset (rst_n low, async):
- rgb=0, target=0, settled=1.
- Tick counter=0, FSM=IDLE.
- Table reloads defaults from the package: entry0=000000, entry1=0000FF (cooling), entry2=FF0000 (heating), entry3=FF00FF; remaining entries 0. Defaults scale to CH_W by taking the MSBs.

Lookup pipeline:
- sel is registered into sel_q.
- target <= table[sel_q] on the next edge, so target follows a sel change 2 cycles later.
- A write to lut_addr takes effect at the edge where lut_we is high. If lut_addr==sel_q, the new data reaches target one cycle later (write-first).

Tick counter:
- Free-running 0..TICK_DIV-1; tick pulses in the cycle the counter wraps.
- TICK_DIV=1 gives a tick every cycle.
- The counter is never reset by sel or table activity.

FSM:
- IDLE -> FADE when target != rgb.
- In FADE, on each tick every channel moves toward its target channel by min(STEP, |diff|): no overshoot, no wrap.
- Channels move independently and simultaneously.
- FADE -> IDLE on the tick where rgb becomes equal to target.
- settled is high in IDLE and low in FADE. It drops on the cycle target first differs from rgb, registered.

Boundary cases:
- sel change mid-fade: target is replaced; the fade continues from the current rgb without restarting the counter.
- Step arithmetic uses CH_W+1 bits, so channel 0 with STEP never underflows and FF never overflows.
- Target returning to rgb before a tick: FSM goes to IDLE on the next cycle with no step taken.
- Reset mid-fade: immediate return to reset values.

Optional Feature:
RGB_BLINK_EN
- Defined: sel_q == 3 (heating and cooling both asserted, fault) enters state BLINK.
  - rgb snaps to target with no fade.
  - rgb toggles between target and 0 every BLINK_TICKS ticks.
  - settled is held 0.
  - Leaving sel 3 returns to FADE from the current rgb.
- Undefined: entry 3 behaves like any other entry; state BLINK and its counter are not present.

Decomposition:
- Package rgb_pkg holds:
  - FSM state enum (IDLE, FADE, BLINK);
  - default table constant (8 x 24-bit);
  - function step_toward(cur, tgt, step) returning the clamped next channel value.
- Sub-module rgb_channel_ramp: one channel register plus step_toward. It is instantiated 3 times and emits a per-channel equal flag.
- Top level holds the table, sel_q, target, tick counter and FSM.

Test Plan:
All scenarios use TICK_DIV=4, STEP=0x40, CH_W=8 unless noted.
1. Reset with sel=0: rgb=000000, target=000000, settled=1 during and after reset.
2. sel 0->2:
   - target=FF0000 two cycles later; settled falls.
   - R steps 00,40,80,C0,FF (last step clamped), one step per 4 clk.
   - G and B stay 00; settled rises after the FF step.
3. Change sel to 1 when R=80:
   - R steps 80,40,00 while B steps 00,40,80,C0,FF on the same ticks.
   - Settled at 0000FF.
4. sel=1, settled at 0000FF; write lut_addr=1, lut_wdata=00FF00: target=00FF00 one cycle after the write, then fade completes to 00FF00.
5. Pulse rst_n low mid-fade (rgb=400000), asynchronously between edges:
   - rgb=000000 and settled=1 immediately.
   - Table entry 1 reads 0000FF again.
6. With RGB_BLINK_EN and BLINK_TICKS=2, sel=3: rgb alternates FF00FF/000000 every 8 clk and settled=0. Without the macro, sel=3 fades normally to FF00FF.
